// File: rtl/multisim_apb_tracker.sv
// Passive APB bus tracker: classifies each cycle's bus phase, reports completed transfers
// and keeps saturating statistics plus sticky timeout and protocol-violation flags.
module multisim_apb_tracker #(
   parameter int  NUM_SLV = 4,
   parameter int  CNT_W   = 16,
   parameter int  WAIT_W  = 8,
   parameter int  TIMEOUT = 255,
   localparam int SLV_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic [NUM_SLV-1:0] i_apb_psel,
   input  logic               i_apb_penable,
   input  logic               i_apb_pwrite,
   input  logic               i_apb_pready,
   input  logic               i_apb_pslverr,
   output logic [3:0]         o_state,
   output logic [SLV_W-1:0]   o_slv_idx,
   output logic               o_xfer_done,
   output logic               o_xfer_write,
   output logic               o_xfer_err,
   output logic [WAIT_W-1:0]  o_wait_cnt,
   output logic [CNT_W-1:0]   o_wr_cnt,
   output logic [CNT_W-1:0]   o_rd_cnt,
   output logic [CNT_W-1:0]   o_err_cnt,
   output logic               o_timeout,
   output logic               o_proto_err
);
   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_SETUP  = 4'b0010,
      ST_ACCESS = 4'b0100
   } multisim_apb_state_t;

   localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

   multisim_apb_state_t state_reg, state_next;
   logic                synced_reg, pready_prev_reg, pwrite_lat_reg;
   logic [NUM_SLV-1:0]  psel_lat_reg;
   logic [SLV_W-1:0]    slv_idx_reg, slv_idx_next;
   logic [WAIT_W-1:0]   wait_cnt_reg, wait_inc;
   logic                xfer_done_reg, xfer_write_reg, xfer_err_reg;
   logic                timeout_reg, proto_err_reg;
   logic                multi_sel, prev_setup, prev_wait, is_access, legal_pred;
   logic                xfer_done_next, count_en, violation;
   logic [2:0]          stat_inc;
   logic [3*CNT_W-1:0]  stat_flat;

   always_comb begin
      state_next = ST_IDLE;
      if (|i_apb_psel)
         state_next = i_apb_penable ? ST_ACCESS : ST_SETUP;
   end

   // Lowest set bit wins when several selects are (illegally) active.
   always_comb begin
      slv_idx_next = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--)
         if (i_apb_psel[i])
            slv_idx_next = SLV_W'(i);
   end

   assign multi_sel      = |(i_apb_psel & (i_apb_psel - NUM_SLV'(1)));
   assign prev_setup     = (state_reg == ST_SETUP);
   assign prev_wait      = (state_reg == ST_ACCESS) && !pready_prev_reg;
   assign is_access      = (state_next == ST_ACCESS);
   assign legal_pred     = prev_setup || prev_wait;
   assign xfer_done_next = is_access && i_apb_pready;
   assign count_en       = synced_reg && xfer_done_next;
   assign wait_inc       = (&wait_cnt_reg) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);

   assign violation = multi_sel
                    || (prev_setup && !is_access)
                    || (is_access && !legal_pred)
                    || (is_access && legal_pred &&
                        ((i_apb_psel != psel_lat_reg) || (i_apb_pwrite != pwrite_lat_reg)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         synced_reg      <= 1'b0;
         pready_prev_reg <= 1'b0;
         pwrite_lat_reg  <= 1'b0;
         psel_lat_reg    <= '0;
         slv_idx_reg     <= '0;
         wait_cnt_reg    <= '0;
         xfer_done_reg   <= 1'b0;
         xfer_write_reg  <= 1'b0;
         xfer_err_reg    <= 1'b0;
         timeout_reg     <= 1'b0;
         proto_err_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pready_prev_reg <= i_apb_pready;
         xfer_done_reg   <= count_en;
         if (state_next == ST_IDLE)
            synced_reg <= 1'b1;
         if (state_next == ST_SETUP) begin
            slv_idx_reg    <= slv_idx_next;
            pwrite_lat_reg <= i_apb_pwrite;
            psel_lat_reg   <= i_apb_psel;
            wait_cnt_reg   <= '0;
         end
         if (is_access && !i_apb_pready)
            wait_cnt_reg <= wait_inc;
         if (count_en) begin
            xfer_write_reg <= pwrite_lat_reg;
            xfer_err_reg   <= i_apb_pslverr;
         end
         if (i_clr)
            timeout_reg <= 1'b0;
         else if ((TIMEOUT != 0) && synced_reg && is_access && !i_apb_pready &&
                  (wait_inc == TIMEOUT_W))
            timeout_reg <= 1'b1;
         if (i_clr)
            proto_err_reg <= 1'b0;
         else if (synced_reg && violation)
            proto_err_reg <= 1'b1;
      end
   end

   // Statistics counters: 0 = writes, 1 = reads, 2 = slave errors.
   assign stat_inc = {count_en && i_apb_pslverr, count_en && !pwrite_lat_reg,
                      count_en && pwrite_lat_reg};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_stat
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               cnt_reg <= '0;
            else if (i_clr)
               cnt_reg <= '0;
            else if (stat_inc[gi] && !(&cnt_reg))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
         assign stat_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate

   assign o_state      = state_reg;
   assign o_slv_idx    = slv_idx_reg;
   assign o_xfer_done  = xfer_done_reg;
   assign o_xfer_write = xfer_write_reg;
   assign o_xfer_err   = xfer_err_reg;
   assign o_wait_cnt   = wait_cnt_reg;
   assign o_wr_cnt     = stat_flat[0*CNT_W +: CNT_W];
   assign o_rd_cnt     = stat_flat[1*CNT_W +: CNT_W];
   assign o_err_cnt    = stat_flat[2*CNT_W +: CNT_W];
   assign o_timeout    = timeout_reg;
   assign o_proto_err  = proto_err_reg;
endmodule

// File: tb/tb_multisim_apb_tracker.sv
// Bench for multisim_apb_tracker: narrow counters and a short timeout so saturation and
// timeout boundaries are reachable; completed transfers are checked against a scoreboard.
module tb_multisim_apb_tracker;
   localparam int NUM_SLV = 4;
   localparam int CNT_W   = 2;
   localparam int WAIT_W  = 4;
   localparam int TIMEOUT = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               i_clr = 1'b0;
   logic [NUM_SLV-1:0] i_apb_psel = '0;
   logic               i_apb_penable = 1'b0;
   logic               i_apb_pwrite = 1'b0;
   logic               i_apb_pready = 1'b0;
   logic               i_apb_pslverr = 1'b0;
   logic [3:0]         o_state;
   logic [1:0]         o_slv_idx;
   logic               o_xfer_done, o_xfer_write, o_xfer_err;
   logic [WAIT_W-1:0]  o_wait_cnt;
   logic [CNT_W-1:0]   o_wr_cnt, o_rd_cnt, o_err_cnt;
   logic               o_timeout, o_proto_err;

   typedef struct {
      logic       wr;
      logic       err;
      logic [1:0] slv;
      logic [3:0] waits;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   multisim_apb_tracker #(
      .NUM_SLV(NUM_SLV), .CNT_W(CNT_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_clr(i_clr),
      .i_apb_psel(i_apb_psel), .i_apb_penable(i_apb_penable), .i_apb_pwrite(i_apb_pwrite),
      .i_apb_pready(i_apb_pready), .i_apb_pslverr(i_apb_pslverr),
      .o_state(o_state), .o_slv_idx(o_slv_idx), .o_xfer_done(o_xfer_done),
      .o_xfer_write(o_xfer_write), .o_xfer_err(o_xfer_err), .o_wait_cnt(o_wait_cnt),
      .o_wr_cnt(o_wr_cnt), .o_rd_cnt(o_rd_cnt), .o_err_cnt(o_err_cnt),
      .o_timeout(o_timeout), .o_proto_err(o_proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every done pulse must match the oldest expected transfer.
   always @(negedge clk) begin
      if (rst_n && o_xfer_done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected got done pulse, exp none pending");
         end else begin
            mon_e = exp_q.pop_front();
            $display("xfer slv=%0d wr=%0d err=%0d waits=%0d", o_slv_idx, o_xfer_write,
                     o_xfer_err, o_wait_cnt);
            if ({o_xfer_write, o_xfer_err, o_slv_idx, o_wait_cnt} !==
                {mon_e.wr, mon_e.err, mon_e.slv, mon_e.waits}) begin
               errors++;
               $display("FAIL xfer_fields got wr=%0d err=%0d slv=%0d wait=%0d exp wr=%0d err=%0d slv=%0d wait=%0d",
                        o_xfer_write, o_xfer_err, o_slv_idx, o_wait_cnt,
                        mon_e.wr, mon_e.err, mon_e.slv, mon_e.waits);
            end
         end
      end
   end

   task automatic drive(input logic [3:0] psel, input logic en, input logic wr,
                        input logic rdy, input logic err, input logic clr);
      i_apb_psel    = psel;
      i_apb_penable = en;
      i_apb_pwrite  = wr;
      i_apb_pready  = rdy;
      i_apb_pslverr = err;
      i_clr         = clr;
      @(negedge clk);
   endtask

   task automatic xfer(input int slv, input logic wr, input int waits, input logic err,
                       input logic clr_at_end);
      logic [3:0] sel;
      exp_t       e;
      sel     = 4'b0001 << slv;
      e.wr    = wr;
      e.err   = err;
      e.slv   = 2'(slv);
      e.waits = (waits > 15) ? 4'hF : 4'(waits);
      exp_q.push_back(e);
      drive(sel, 1'b0, wr, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < waits; k++)
         drive(sel, 1'b1, wr, 1'b0, 1'b0, 1'b0);
      drive(sel, 1'b1, wr, 1'b1, err, clr_at_end);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (o_state !== 4'b0001) begin errors++; $display("FAIL reset_state got %b exp 0001", o_state); end
      checks++; if ({o_xfer_done, o_xfer_write, o_xfer_err, o_timeout, o_proto_err} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 00000", {o_xfer_done, o_xfer_write, o_xfer_err, o_timeout, o_proto_err}); end
      checks++; if ({o_wr_cnt, o_rd_cnt, o_err_cnt, o_wait_cnt, o_slv_idx} !== '0) begin
         errors++; $display("FAIL reset_counts got wr=%0d rd=%0d err=%0d wait=%0d slv=%0d exp all 0",
                            o_wr_cnt, o_rd_cnt, o_err_cnt, o_wait_cnt, o_slv_idx); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_write;
      exp_t e;
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e.wr = 1'b1; e.err = 1'b0; e.slv = 2'd0; e.waits = 4'd0;
      exp_q.push_back(e);
      drive(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (o_state !== 4'b0010) begin errors++; $display("FAIL basic_setup_state got %b exp 0010", o_state); end
      drive(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (o_state !== 4'b0100) begin errors++; $display("FAIL basic_access_state got %b exp 0100", o_state); end
      checks++; if (o_xfer_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", o_xfer_done); end
      checks++; if (o_wr_cnt !== 2'd1) begin errors++; $display("FAIL basic_wr_cnt got %0d exp 1", o_wr_cnt); end
      checks++; if (o_wait_cnt !== 4'd0) begin errors++; $display("FAIL basic_wait got %0d exp 0", o_wait_cnt); end
      checks++; if (o_slv_idx !== 2'd0) begin errors++; $display("FAIL basic_slv got %0d exp 0", o_slv_idx); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_xfer_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", o_xfer_done); end
      checks++; if (o_state !== 4'b0001) begin errors++; $display("FAIL basic_idle_state got %b exp 0001", o_state); end
   endtask

   task automatic test_read_wait;
      xfer(2, 1'b0, 3, 1'b1, 1'b0);
      checks++; if (o_wait_cnt !== 4'd3) begin errors++; $display("FAIL rdwait_wait got %0d exp 3", o_wait_cnt); end
      checks++; if (o_rd_cnt !== 2'd1) begin errors++; $display("FAIL rdwait_rd_cnt got %0d exp 1", o_rd_cnt); end
      checks++; if (o_err_cnt !== 2'd1) begin errors++; $display("FAIL rdwait_err_cnt got %0d exp 1", o_err_cnt); end
      checks++; if (o_xfer_err !== 1'b1) begin errors++; $display("FAIL rdwait_xfer_err got %b exp 1", o_xfer_err); end
      checks++; if (o_slv_idx !== 2'd2) begin errors++; $display("FAIL rdwait_slv got %0d exp 2", o_slv_idx); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      xfer(1, 1'b1, 1, 1'b0, 1'b0);
      xfer(3, 1'b0, 0, 1'b0, 1'b0);
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL b2b_proto got %b exp 0", o_proto_err); end
      checks++; if ({o_wr_cnt, o_rd_cnt} !== {2'd2, 2'd2}) begin
         errors++; $display("FAIL b2b_counts got wr=%0d rd=%0d exp wr=2 rd=2", o_wr_cnt, o_rd_cnt); end
      checks++; if (o_slv_idx !== 2'd3) begin errors++; $display("FAIL b2b_slv got %0d exp 3", o_slv_idx); end
   endtask

   task automatic test_midreset;
      drive(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (o_wait_cnt !== 4'd1) begin errors++; $display("FAIL midrst_wait_before got %0d exp 1", o_wait_cnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_state !== 4'b0001) begin errors++; $display("FAIL midrst_async_state got %b exp 0001", o_state); end
      checks++; if ({o_wr_cnt, o_rd_cnt, o_wait_cnt, o_slv_idx} !== '0) begin
         errors++; $display("FAIL midrst_async_counts got wr=%0d rd=%0d wait=%0d slv=%0d exp all 0",
                            o_wr_cnt, o_rd_cnt, o_wait_cnt, o_slv_idx); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL midrst_proto got %b exp 0", o_proto_err); end
      checks++; if (o_wr_cnt !== 2'd0) begin errors++; $display("FAIL midrst_unsynced_wr got %0d exp 0", o_wr_cnt); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      xfer(1, 1'b0, 0, 1'b0, 1'b0);
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_rd_cnt !== 2'd1) begin errors++; $display("FAIL midrst_synced_rd got %0d exp 1", o_rd_cnt); end
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL midrst_proto_after got %b exp 0", o_proto_err); end
   endtask

   task automatic test_timeout;
      exp_t e;
      e.wr = 1'b0; e.err = 1'b0; e.slv = 2'd1; e.waits = 4'd15;
      exp_q.push_back(e);
      drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++; if (o_wait_cnt !== 4'((k > 15) ? 15 : k)) begin
            errors++; $display("FAIL tmo_wait_%0d got %0d exp %0d", k, o_wait_cnt, (k > 15) ? 15 : k); end
         checks++; if (o_timeout !== (k >= TIMEOUT)) begin
            errors++; $display("FAIL tmo_flag_%0d got %b exp %b", k, o_timeout, k >= TIMEOUT); end
      end
      drive(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (o_rd_cnt !== 2'd2) begin errors++; $display("FAIL tmo_rd_cnt got %0d exp 2", o_rd_cnt); end
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL tmo_proto got %b exp 0", o_proto_err); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clr got %b exp 0", o_timeout); end
      checks++; if ({o_wr_cnt, o_rd_cnt, o_err_cnt} !== '0) begin
         errors++; $display("FAIL tmo_clr_counts got wr=%0d rd=%0d err=%0d exp 0", o_wr_cnt, o_rd_cnt, o_err_cnt); end
      checks++; if (o_wait_cnt !== 4'd15) begin errors++; $display("FAIL tmo_clr_wait got %0d exp 15", o_wait_cnt); end
   endtask

   task automatic test_protocol;
      drive(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_setup_ok got %b exp 0", o_proto_err); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_setup_idle got %b exp 1", o_proto_err); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr got %b exp 0", o_proto_err); end
      drive(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_multi got %b exp 1", o_proto_err); end
      checks++; if (o_slv_idx !== 2'd0) begin errors++; $display("FAIL proto_multi_slv got %0d exp 0", o_slv_idx); end
      // Violation (SETUP then IDLE) coincides with clear: clear must win.
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr_wins got %b exp 0", o_proto_err); end
      drive(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_slv_idx !== 2'd2) begin errors++; $display("FAIL proto_multi_slv2 got %0d exp 2", o_slv_idx); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_access_no_setup got %b exp 1", o_proto_err); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr2 got %b exp 0", o_proto_err); end
      drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_wait_ok got %b exp 0", o_proto_err); end
      drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_pwrite_change got %b exp 1", o_proto_err); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_psel_change got %b exp 1", o_proto_err); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr3 got %b exp 0", o_proto_err); end
   endtask

   task automatic test_saturation;
      for (int i = 1; i <= 5; i++) begin
         xfer(0, 1'b1, 0, 1'b0, 1'b0);
         checks++; if (o_wr_cnt !== 2'((i > 3) ? 3 : i)) begin
            errors++; $display("FAIL sat_wr_%0d got %0d exp %0d", i, o_wr_cnt, (i > 3) ? 3 : i); end
      end
      xfer(0, 1'b1, 0, 1'b0, 1'b1);
      checks++; if (o_wr_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr_with_done got %0d exp 0", o_wr_cnt); end
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (o_wr_cnt !== 2'd0) begin errors++; $display("FAIL sat_after_clr got %0d exp 0", o_wr_cnt); end
      checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL sat_proto got %b exp 0", o_proto_err); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_read_wait();
      test_back_to_back();
      test_midreset();
      test_timeout();
      test_protocol();
      test_saturation();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
